// File: rtl/lsu_ld_sched_if.sv
// Command, AXI read (AR/R) and SRAM write bundle of the LSU load scheduler.
// The master modport is the scheduler's view; slave is its environment.
interface lsu_ld_sched_if #(
    parameter int ADDR_W  = 10,
    parameter int SRAM_AW = 12,
    parameter int DATA_W  = 64
);
    logic               cmd_vld;
    logic               cmd_rdy;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [7:0]         cmd_num;
    logic [2:0]         cmd_len;
    logic [2:0]         cmd_str;
    logic [SRAM_AW-1:0] cmd_sram_addr;

    logic [7:0]         ar_id;
    logic [ADDR_W-1:0]  ar_addr;
    logic [7:0]         ar_len;
    logic [2:0]         ar_size;
    logic [1:0]         ar_burst;
    logic               ar_vld;
    logic               ar_rdy;

    logic [7:0]         r_id;
    logic [DATA_W-1:0]  r_data;
    logic [1:0]         r_resp;
    logic               r_last;
    logic               r_vld;
    logic               r_rdy;

    logic               wr_en;
    logic [SRAM_AW-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;

    logic               done;
    logic               err;
    logic [15:0]        perf_cycles;

    modport master (
        input  cmd_vld, cmd_addr, cmd_num, cmd_len, cmd_str, cmd_sram_addr,
        input  ar_rdy, r_id, r_data, r_resp, r_last, r_vld,
        output cmd_rdy, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_vld,
        output r_rdy, wr_en, wr_addr, wr_data, done, err, perf_cycles
    );

    modport slave (
        output cmd_vld, cmd_addr, cmd_num, cmd_len, cmd_str, cmd_sram_addr,
        output ar_rdy, r_id, r_data, r_resp, r_last, r_vld,
        input  cmd_rdy, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_vld,
        input  r_rdy, wr_en, wr_addr, wr_data, done, err, perf_cycles
    );
endinterface

// File: rtl/lsu_ld_sched.sv
// LSU load scheduler: splits one load command into strided AXI read bursts and
// steers R beats to sequential SRAM addresses. Optional macro: LSU_LD_SCHED_PERF_EN.
module lsu_ld_sched #(
    parameter int MAX_OUTSTD = 4,
    parameter int ADDR_W     = 10,
    parameter int SRAM_AW    = 12,
    parameter int DATA_W     = 64
) (
    input  logic          clk,
    input  logic          rst,
    lsu_ld_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_OUTSTD);

    state_t             r_state;
    state_t             w_stateNext;
    logic [ADDR_W-1:0]  r_arAddr;
    logic [7:0]         r_issued;
    logic [7:0]         r_num;
    logic [7:0]         r_rBurst;
    logic [2:0]         r_len;
    logic [2:0]         r_str;
    logic [2:0]         r_beat;
    logic [3:0]         r_outstd;
    logic [SRAM_AW-1:0] r_wrAddr;
    logic               r_arVld;
    logic               r_err;

    logic               w_accept;
    logic               w_arHs;
    logic               w_rRdy;
    logic               w_rHs;
    logic               w_rLastHs;
    logic               w_rErr;
    logic               w_lastAr;
    logic [3:0]         w_outstdNext;
    logic [7:0]         w_issuedNext;
    logic [ADDR_W-1:0]  w_step;
    logic [DATA_W-1:0]  w_rData;

    assign w_accept  = (r_state == IDLE) && bus.cmd_vld;
    assign w_arHs    = r_arVld && bus.ar_rdy;
    assign w_rRdy    = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_rHs     = bus.r_vld && w_rRdy;
    assign w_rLastHs = w_rHs && bus.r_last;
    assign w_rData   = bus.r_data;

    // A stray rlast with nothing outstanding is flagged as an error but must not underflow the count.
    assign w_outstdNext = r_outstd + {3'b000, w_arHs}
                        - {3'b000, w_rLastHs && (r_outstd != 4'd0)};
    assign w_issuedNext = r_issued + {7'd0, w_arHs};
    assign w_lastAr     = w_arHs && (w_issuedNext == r_num);
    assign w_step       = ADDR_W'({1'b0, r_str} + 4'd1);
    assign w_rErr       = (bus.r_resp != 2'b00)
                        || (bus.r_last != (r_beat == r_len))
                        || (bus.r_id != r_rBurst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_vld) w_stateNext = (bus.cmd_num == 8'd0) ? DONE : ISSUE;
            ISSUE:   if (w_lastAr) w_stateNext = DRAIN;
            DRAIN:   if (w_outstdNext == 4'd0) w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // ar_vld is registered from next-cycle occupancy, so a slot freed by rlast reopens one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arAddr <= '0;
            r_issued <= '0;
            r_num    <= '0;
            r_rBurst <= '0;
            r_len    <= '0;
            r_str    <= '0;
            r_beat   <= '0;
            r_outstd <= '0;
            r_wrAddr <= '0;
            r_arVld  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_arAddr <= bus.cmd_addr;
            r_issued <= '0;
            r_num    <= bus.cmd_num;
            r_rBurst <= '0;
            r_len    <= bus.cmd_len;
            r_str    <= bus.cmd_str;
            r_beat   <= '0;
            r_outstd <= '0;
            r_wrAddr <= bus.cmd_sram_addr;
            r_arVld  <= (bus.cmd_num != 8'd0);
            r_err    <= 1'b0;
        end else begin
            if (w_arHs) begin
                r_arAddr <= r_arAddr + w_step;
            end
            r_issued <= w_issuedNext;
            r_outstd <= w_outstdNext;
            r_arVld  <= (r_state == ISSUE) && (w_issuedNext < r_num) && (w_outstdNext < LP_MAX);
            if (w_rHs) begin
                r_wrAddr <= r_wrAddr + SRAM_AW'(1);
                if (bus.r_last) begin
                    r_beat   <= '0;
                    r_rBurst <= r_rBurst + 8'd1;
                end else begin
                    r_beat   <= r_beat + 3'd1;
                end
                if (w_rErr) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_rdy  = (r_state == IDLE);
    assign bus.ar_id    = r_issued;
    assign bus.ar_addr  = r_arAddr;
    assign bus.ar_len   = {5'b00000, r_len};
    assign bus.ar_size  = 3'd3;
    assign bus.ar_burst = 2'b01;
    assign bus.ar_vld   = r_arVld;
    assign bus.r_rdy    = w_rRdy;
    assign bus.wr_en    = w_rHs;
    assign bus.wr_addr  = r_wrAddr;
    assign bus.wr_data  = w_rData;
    assign bus.done     = (r_state == DONE);
    assign bus.err      = r_err;

`ifdef LSU_LD_SCHED_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= 16'd1;
        end else if ((r_state != IDLE) && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign bus.perf_cycles = r_perf;
`else
    assign bus.perf_cycles = 16'h0;
`endif
endmodule

// File: tb/tb_lsu_ld_sched.sv
// Randomized bench for lsu_ld_sched: an AXI read slave plus a transaction-level model
// of the command's burst/beat bookkeeping, compared against the DUT every cycle.
module tb_lsu_ld_sched;
    localparam int ADDR_W     = 10;
    localparam int SRAM_AW    = 12;
    localparam int DATA_W     = 64;
    localparam int MAX_OUTSTD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsu_ld_sched_if #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .DATA_W(DATA_W)) bus ();

    lsu_ld_sched #(
        .MAX_OUTSTD(MAX_OUTSTD), .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int nVec  = 0;
    int nFail = 0;

    // Model: phase flags plus burst/beat counts of the current command.
    bit mIdle, mBusy, mDone, mErr;
    int mNum, mLen, mStr, mAddr, mSram;
    int mIssued, mCompleted, mBeats, mBib, mPerf;
    bit cmdPending;

    int slvQ[$];
    int slvBeat;

    int arRdyPct = 100;
    int rVldPct = 100;
    int errPct = 0;
    int forceRespBeat = -1;
    bit rHold = 1'b0;

    int seenAr[$];
    int seenId[$];
    int seenWr[$];
    int doneCnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bit expArVld();
        return mBusy && (mIssued < mNum) && ((mIssued - mCompleted) < MAX_OUTSTD);
    endfunction

    task automatic resetModel();
        mIdle = 1; mBusy = 0; mDone = 0; mErr = 0;
        mNum = 0; mLen = 0; mStr = 0; mAddr = 0; mSram = 0;
        mIssued = 0; mCompleted = 0; mBeats = 0; mBib = 0; mPerf = 0;
        cmdPending = 0;
        slvQ.delete();
        slvBeat = 0;
    endtask

    task automatic applyStimulus();
        bus.cmd_vld = cmdPending;
        bus.ar_rdy  = ($urandom_range(99) < arRdyPct);
        bus.r_vld   = 1'b0;
        bus.r_last  = 1'b0;
        bus.r_resp  = 2'b00;
        bus.r_id    = 8'd0;
        bus.r_data  = {$urandom, $urandom};
        if (mBusy && slvQ.size() > 0 && !rHold && $urandom_range(99) < rVldPct) begin
            bus.r_vld  = 1'b1;
            bus.r_id   = 8'(slvQ[0]);
            bus.r_last = (slvBeat == mLen);
            if (mBeats == forceRespBeat) bus.r_resp = 2'b10;
            if ($urandom_range(99) < errPct) begin
                case ($urandom_range(2))
                    0:       bus.r_resp = 2'($urandom_range(3, 1));
                    1:       bus.r_id = bus.r_id ^ 8'h55;
                    default: if (slvBeat < mLen) bus.r_last = 1'b1;
                endcase
            end
        end else if (!mBusy && $urandom_range(3) == 0) begin
            bus.r_vld  = 1'b1;
            bus.r_last = 1'($urandom);
            bus.r_id   = 8'($urandom);
        end
    endtask

    task automatic checkOutput();
        bit arV;
        arV = expArVld();
        check("cmd_rdy", 64'(bus.cmd_rdy), 64'(mIdle));
        check("ar_vld", 64'(bus.ar_vld), 64'(arV));
        if (arV) begin
            check("ar_id", 64'(bus.ar_id), 64'(mIssued));
            check("ar_addr", 64'(bus.ar_addr), 64'((mAddr + mIssued * (mStr + 1)) % 1024));
            check("ar_len", 64'(bus.ar_len), 64'(mLen));
            check("ar_size", 64'(bus.ar_size), 64'd3);
            check("ar_burst", 64'(bus.ar_burst), 64'd1);
        end
        check("r_rdy", 64'(bus.r_rdy), 64'(mBusy));
        check("wr_en", 64'(bus.wr_en), 64'(bus.r_vld && mBusy));
        if (bus.r_vld && mBusy) begin
            check("wr_addr", 64'(bus.wr_addr), 64'((mSram + mBeats) % 4096));
            check("wr_data", bus.wr_data, bus.r_data);
        end
        check("done", 64'(bus.done), 64'(mDone));
        check("err", 64'(bus.err), 64'(mErr));
`ifdef LSU_LD_SCHED_PERF_EN
        check("perf_cycles", 64'(bus.perf_cycles), 64'(mPerf));
`else
        check("perf_cycles", 64'(bus.perf_cycles), 64'd0);
`endif
        if (bus.ar_vld && bus.ar_rdy) begin
            seenAr.push_back(int'(bus.ar_addr));
            seenId.push_back(int'(bus.ar_id));
        end
        if (bus.wr_en) seenWr.push_back(int'(bus.wr_addr));
        if (bus.done) doneCnt++;
    endtask

    task automatic updateModel();
        bit arHs;
        if (mBusy || mDone) mPerf = (mPerf < 65535) ? mPerf + 1 : 65535;
        if (mIdle) begin
            if (bus.cmd_vld) begin
                mNum = int'(bus.cmd_num); mLen = int'(bus.cmd_len); mStr = int'(bus.cmd_str);
                mAddr = int'(bus.cmd_addr); mSram = int'(bus.cmd_sram_addr);
                mErr = 0; mIssued = 0; mCompleted = 0; mBeats = 0; mBib = 0; mPerf = 1;
                mIdle = 0;
                if (mNum == 0) mDone = 1; else mBusy = 1;
                cmdPending = 0;
            end
        end else if (mDone) begin
            mDone = 0;
            mIdle = 1;
        end else if (mBusy) begin
            arHs = expArVld() && bus.ar_rdy;
            if (bus.r_vld) begin
                if (bus.r_resp != 2'b00 || bus.r_last != (mBib == mLen) || int'(bus.r_id) != mCompleted % 256)
                    mErr = 1;
                mBeats++;
                if (bus.r_last) begin
                    mCompleted++;
                    mBib = 0;
                    void'(slvQ.pop_front());
                    slvBeat = 0;
                end else begin
                    mBib = (mBib + 1) % 8;
                    slvBeat++;
                end
            end
            if (arHs) begin
                slvQ.push_back(mIssued);
                mIssued++;
            end
            if (mIssued == mNum && mCompleted == mNum) begin
                mBusy = 0;
                mDone = 1;
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput();
        updateModel();
    endtask

    task automatic startCmd(input int addr, input int num, input int len, input int str, input int sram);
        seenAr.delete(); seenId.delete(); seenWr.delete();
        doneCnt = 0;
        bus.cmd_addr      = ADDR_W'(addr);
        bus.cmd_num       = 8'(num);
        bus.cmd_len       = 3'(len);
        bus.cmd_str       = 3'(str);
        bus.cmd_sram_addr = SRAM_AW'(sram);
        cmdPending        = 1;
    endtask

    task automatic waitIdle();
        int budget = 0;
        do begin
            stepCycle();
            budget++;
        end while (!(mIdle && !cmdPending) && budget < 3000);
        check("cmd_complete_in_budget", 64'(budget < 3000), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int budget;
        rst = 1'b1;
        bus.cmd_vld = 0; bus.cmd_addr = '0; bus.cmd_num = '0; bus.cmd_len = '0;
        bus.cmd_str = '0; bus.cmd_sram_addr = '0; bus.ar_rdy = 0;
        bus.r_vld = 0; bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 0;
        resetModel();
        @(negedge clk);
        #1;
        checkOutput();
        check("reset_ar_id", 64'(bus.ar_id), 64'd0);
        check("reset_ar_addr", 64'(bus.ar_addr), 64'd0);
        check("reset_wr_addr", 64'(bus.wr_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single burst");
        startCmd(12'h010, 1, 3, 0, 12'h100);
        waitIdle();
        check("single_ar_count", 64'(seenAr.size()), 64'd1);
        check("single_ar_addr", 64'(at(seenAr, 0)), 64'h010);
        check("single_ar_id", 64'(at(seenId, 0)), 64'd0);
        check("single_wr_count", 64'(seenWr.size()), 64'd4);
        check("single_wr_first", 64'(at(seenWr, 0)), 64'h100);
        check("single_wr_last", 64'(at(seenWr, 3)), 64'h103);
        check("single_done_pulses", 64'(doneCnt), 64'd1);
        check("single_err", 64'(bus.err), 64'd0);

        $display("[TB] outstanding limit");
        rHold = 1'b1;
        startCmd(0, 6, 1, 2, 12'h200);
        for (int i = 0; i < 20; i++) stepCycle();
        check("outstd_ar_count", 64'(seenAr.size()), 64'd4);
        check("outstd_ar0", 64'(at(seenAr, 0)), 64'h000);
        check("outstd_ar1", 64'(at(seenAr, 1)), 64'h003);
        check("outstd_ar2", 64'(at(seenAr, 2)), 64'h006);
        check("outstd_ar3", 64'(at(seenAr, 3)), 64'h009);
        check("outstd_ar_vld_low", 64'(bus.ar_vld), 64'd0);
        rHold = 1'b0;
        waitIdle();
        check("outstd_ar4", 64'(at(seenAr, 4)), 64'h00C);
        check("outstd_ar5", 64'(at(seenAr, 5)), 64'h00F);

        $display("[TB] address wrap");
        startCmd(12'h3FE, 3, 0, 1, 12'hFFE);
        waitIdle();
        check("wrap_ar0", 64'(at(seenAr, 0)), 64'h3FE);
        check("wrap_ar1", 64'(at(seenAr, 1)), 64'h000);
        check("wrap_ar2", 64'(at(seenAr, 2)), 64'h002);
        check("wrap_wr0", 64'(at(seenWr, 0)), 64'hFFE);
        check("wrap_wr1", 64'(at(seenWr, 1)), 64'hFFF);
        check("wrap_wr2", 64'(at(seenWr, 2)), 64'h000);

        $display("[TB] AR backpressure");
        arRdyPct = 0;
        startCmd(12'h055, 2, 1, 0, 12'h010);
        for (int i = 0; i < 6; i++) stepCycle();
        check("bp_ar_vld_held", 64'(bus.ar_vld), 64'd1);
        check("bp_ar_addr_held", 64'(bus.ar_addr), 64'h055);
        check("bp_ar_id_held", 64'(bus.ar_id), 64'd0);
        arRdyPct = 100;
        waitIdle();

        $display("[TB] empty command");
        startCmd(12'h123, 0, 2, 0, 12'h000);
        waitIdle();
        check("empty_ar_count", 64'(seenAr.size()), 64'd0);
        check("empty_done_pulses", 64'(doneCnt), 64'd1);

        $display("[TB] error response");
        forceRespBeat = 1;
        startCmd(12'h020, 1, 3, 0, 12'h300);
        waitIdle();
        forceRespBeat = -1;
        check("error_err_set", 64'(bus.err), 64'd1);
        check("error_wr_count", 64'(seenWr.size()), 64'd4);
        check("error_done_pulses", 64'(doneCnt), 64'd1);
        startCmd(12'h030, 1, 0, 0, 12'h000);
        stepCycle();
        stepCycle();
        check("error_cleared", 64'(bus.err), 64'd0);
        waitIdle();

        $display("[TB] reset during drain");
        rVldPct = 30;
        startCmd(12'h040, 2, 7, 3, 12'h000);
        budget = 0;
        do begin
            stepCycle();
            budget++;
        end while (!(mBusy && mIssued == mNum && mCompleted < mNum) && budget < 200);
        check("reached_drain", 64'(mBusy && mIssued == mNum && mCompleted < mNum), 64'd1);
        @(negedge clk);
        bus.r_vld = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_ar_vld", 64'(bus.ar_vld), 64'd0);
        check("rst_r_rdy", 64'(bus.r_rdy), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.r_vld = 1'b0;
        resetModel();
        rVldPct = 100;
        startCmd(12'h100, 2, 1, 0, 12'h050);
        waitIdle();
        check("post_rst_id0", 64'(at(seenId, 0)), 64'd0);
        check("post_rst_id1", 64'(at(seenId, 1)), 64'd1);

        $display("[TB] random commands");
        errPct = 3;
        for (int n = 0; n < 40; n++) begin
            arRdyPct = $urandom_range(100, 30);
            rVldPct  = $urandom_range(100, 30);
            startCmd($urandom_range(1023), $urandom_range(12), $urandom_range(7),
                     $urandom_range(7), $urandom_range(4095));
            waitIdle();
            for (int g = 0; g < int'($urandom_range(2)); g++) stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
